rom_boot_loader: RTL and testbench
==================================

// Module: rom_boot_loader
// PURPOSE
//  UART boot loader sitting upstream of rv32ima_soc_top: receives a program image over a serial line,
//  writes it word-by-word into the instruction ROM write port, and holds the core in reset until done.
//  Replaces $readmemh preloading for FPGA bring-up; the SoC core only runs after a complete, valid image.
// PARAMETERS
//  CLK_FREQ   50_000_000  clk frequency in Hz
//  BAUD       115200      serial bit rate; localparam CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide)
//  ADDR_W     12          ROM word-address width; capacity 2**ADDR_W words
// PORTS
//  clk         in   1       system clock (CLOCK_50 domain)
//  rst         in   1       asynchronous reset, active-high
//  uart_rxd    in   1       serial input, 8N1, idle high, asynchronous to clk
//  rom_we      out  1       ROM write strobe, one-cycle pulse per word
//  rom_waddr   out  ADDR_W  ROM word address
//  rom_wdata   out  32      ROM write data
//  core_rst    out  1       reset to SoC core, active-high
//  boot_done   out  1       image loaded successfully (sticky until rst)
//  boot_err    out  1       load failed (sticky until rst)
// BEHAVIOUR
//  Reset values: rom_we=0, rom_waddr=0, rom_wdata=0, core_rst=1, boot_done=0, boot_err=0; FSM=S_LEN.
//  RX: 2-flop synchroniser on uart_rxd; falling edge in idle starts a frame; start bit re-checked at
//   CLKS_PER_BIT/2 (high there = glitch, return to idle, no byte); data bits LSB first sampled at bit
//   centres; stop bit sampled at its centre. Stop=1 -> 1-cycle rx_valid with rx_byte; stop=0 -> rx_ferr.
//  Protocol (all multi-byte fields little-endian): 4-byte word count N, then N 32-bit words.
//  FSM states: S_LEN, S_DATA, S_CKSUM (only with BOOT_CKSUM_EN), S_DONE, S_ERR.
//   S_LEN: collect 4 bytes into N. After 4th: N > 2**ADDR_W -> S_ERR; N==0 -> S_CKSUM/S_DONE; else S_DATA.
//   S_DATA: 2-bit byte index assembles word; on 4th byte, rom_we=1 the following cycle with
//    rom_waddr=word index, rom_wdata=assembled word; word index increments after the write.
//    After word N-1 written -> S_CKSUM/S_DONE.
//   S_DONE: boot_done=1, core_rst=0 from the first cycle in S_DONE. Further RX bytes ignored.
//   S_ERR: boot_err=1, core_rst stays 1. Further RX bytes ignored.
//  rx_ferr in any of S_LEN/S_DATA/S_CKSUM -> S_ERR; ignored in S_DONE/S_ERR.
//  Word index never wraps: N is bounded to capacity, so max rom_waddr = 2**ADDR_W-1.
//  rst mid-operation: all state, counters and partial word cleared; host must resend entire image.
//  No timeout; an incomplete image leaves core_rst=1 indefinitely.
// CONFIGURATION
//  BOOT_CKSUM_EN defined: 8-bit running sum (mod 256) of every received byte incl. length bytes;
//   after last word, S_CKSUM takes one byte: equal to sum -> S_DONE, else S_ERR.
//  BOOT_CKSUM_EN undefined: no checksum byte, no S_CKSUM state, sum logic absent.
// STRUCTURE
//  Shared package: FSM state encoding, protocol constants (LEN_BYTES=4, WORD_BYTES=4).
//  One sub-module: boot_uart_rx (synchroniser, bit timer, 8N1 deserialiser; outputs rx_valid,
//   rx_byte, rx_ferr). Top holds protocol FSM, counters, ROM write port, checksum.
// TESTING (bench may override BAUD so CLKS_PER_BIT=16)
//  1 rst=1 -> core_rst=1, rom_we=0, boot_done=0, boot_err=0; release rst, rxd idle -> unchanged.
//  2 send 02 00 00 00, 13 00 00 00, ef be ad de [+4d if CKSUM_EN] -> rom_we pulses twice:
//    (addr 0, 00000013), (addr 1, deadbeef); then boot_done=1, core_rst=0; extra bytes -> no write.
//  3 send 00 00 00 00 [+00 if CKSUM_EN] -> no rom_we; boot_done=1, core_rst=0.
//  4 length 01 10 00 00 (4097 > 4096) -> boot_err=1, core_rst=1, no rom_we; also: stop bit 0 on any
//    byte -> boot_err=1; 1-bit-time-short low glitch on rxd -> no byte, no error.
//  5 rst pulse after 2 data bytes of word 0 -> outputs at reset values; resend case 2 -> same writes
//    starting at addr 0.
//  6 CKSUM_EN: case 2 with checksum 4c -> both words written, then boot_err=1, core_rst=1, boot_done=0.

Source files
------------

// File: rtl/rom_boot_loader_pkg.sv
// Shared types and protocol constants for the UART ROM boot loader.
// Optional checksum stage enabled by defining BOOT_CKSUM_EN.
package rom_boot_loader_pkg;

    localparam int LEN_BYTES  = 4;
    localparam int WORD_BYTES = 4;

`ifdef BOOT_CKSUM_EN
    typedef enum logic [2:0] {
        S_LEN   = 3'd0,
        S_DATA  = 3'd1,
        S_CKSUM = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } boot_state_e;
`else
    typedef enum logic [2:0] {
        S_LEN   = 3'd0,
        S_DATA  = 3'd1,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } boot_state_e;
`endif

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Little-endian byte accumulation: newest byte lands in the top lane.
    function automatic logic [31:0] shift_in_byte(input logic [31:0] acc, input logic [7:0] b);
        return {b, acc[31:8]};
    endfunction

endpackage

// File: rtl/rom_boot_loader_uart_rx.sv
// 8N1 UART receiver: synchroniser, bit timer and deserialiser (module boot_uart_rx).
// Emits one-cycle rx_valid with rx_byte, or one-cycle rx_ferr on a low stop bit.
module boot_uart_rx
    import rom_boot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             meta_q, sync_q, prev_q;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q    <= 1'b1;
            sync_q    <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            meta_q    <= rxd;
            sync_q    <= meta_q;
            prev_q    <= sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = 3'd0;
                if (prev_q && !sync_q) begin
                    state_d = RX_START;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                // Line high again at mid start bit means it was a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    shift_d   = {sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        state_d = RX_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = sync_q;
                    ferr_d  = !sync_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rx_valid = valid_q;
    assign rx_byte  = shift_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/rom_boot_loader.sv
// Boot loader top: length/word protocol FSM driving the ROM write port and core reset.
// Define BOOT_CKSUM_EN to require a trailing 8-bit sum byte before releasing the core.
module rom_boot_loader
    import rom_boot_loader_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rxd,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [31:0]       rom_wdata,
    output logic              core_rst,
    output logic              boot_done,
    output logic              boot_err
);

    localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [31:0] CAPACITY     = 32'd1 << ADDR_W;
`ifdef BOOT_CKSUM_EN
    localparam boot_state_e S_FINAL = S_CKSUM;
`else
    localparam boot_state_e S_FINAL = S_DONE;
`endif

    logic       rx_valid_s, rx_ferr_s;
    logic [7:0] rx_byte_s;

    boot_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rxd      (uart_rxd),
        .rx_valid (rx_valid_s),
        .rx_byte  (rx_byte_s),
        .rx_ferr  (rx_ferr_s)
    );

    boot_state_e       state_q, state_d;
    logic [31:0]       len_q, len_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic              rom_we_q, rom_we_d;
    logic [ADDR_W-1:0] rom_waddr_q, rom_waddr_d;
    logic [31:0]       rom_wdata_q, rom_wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              boot_done_q, boot_done_d;
    logic              boot_err_q, boot_err_d;
    logic [31:0]       new_len_s, new_word_s;
`ifdef BOOT_CKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LEN;
            len_q       <= 32'd0;
            word_q      <= 32'd0;
            byte_idx_q  <= 2'd0;
            word_idx_q  <= '0;
            rom_we_q    <= 1'b0;
            rom_waddr_q <= '0;
            rom_wdata_q <= 32'd0;
            core_rst_q  <= 1'b1;
            boot_done_q <= 1'b0;
            boot_err_q  <= 1'b0;
`ifdef BOOT_CKSUM_EN
            sum_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_q      <= word_d;
            byte_idx_q  <= byte_idx_d;
            word_idx_q  <= word_idx_d;
            rom_we_q    <= rom_we_d;
            rom_waddr_q <= rom_waddr_d;
            rom_wdata_q <= rom_wdata_d;
            core_rst_q  <= core_rst_d;
            boot_done_q <= boot_done_d;
            boot_err_q  <= boot_err_d;
`ifdef BOOT_CKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign new_len_s  = shift_in_byte(len_q, rx_byte_s);
    assign new_word_s = shift_in_byte(word_q, rx_byte_s);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_d      = word_q;
        byte_idx_d  = byte_idx_q;
        word_idx_d  = word_idx_q;
        rom_we_d    = 1'b0;
        rom_waddr_d = rom_waddr_q;
        rom_wdata_d = rom_wdata_q;
`ifdef BOOT_CKSUM_EN
        sum_d       = sum_q;
        if (rx_valid_s && (state_q == S_LEN || state_q == S_DATA)) begin
            sum_d = sum_q + rx_byte_s;
        end else begin
            sum_d = sum_q;
        end
`endif
        case (state_q)
            S_LEN: begin
                if (rx_ferr_s) begin
                    state_d = S_ERR;
                end else if (rx_valid_s) begin
                    len_d      = new_len_s;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'(LEN_BYTES - 1)) begin
                        if (new_len_s > CAPACITY) begin
                            state_d = S_ERR;
                        end else if (new_len_s == 32'd0) begin
                            state_d = S_FINAL;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        state_d = S_LEN;
                    end
                end else begin
                    state_d = S_LEN;
                end
            end
            S_DATA: begin
                if (rx_ferr_s) begin
                    state_d = S_ERR;
                end else if (rx_valid_s) begin
                    word_d     = new_word_s;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'(WORD_BYTES - 1)) begin
                        rom_we_d    = 1'b1;
                        rom_waddr_d = word_idx_q;
                        rom_wdata_d = new_word_s;
                        word_idx_d  = word_idx_q + ADDR_W'(1);
                        // N <= capacity, so the last index never needs to wrap.
                        if (32'(word_idx_q) == len_q - 32'd1) begin
                            state_d = S_FINAL;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef BOOT_CKSUM_EN
            S_CKSUM: begin
                if (rx_ferr_s) begin
                    state_d = S_ERR;
                end else if (rx_valid_s) begin
                    state_d = (rx_byte_s == sum_q) ? S_DONE : S_ERR;
                end else begin
                    state_d = S_CKSUM;
                end
            end
`endif
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
        // Status flags track the next state so they change together with it.
        core_rst_d  = (state_d != S_DONE);
        boot_done_d = (state_d == S_DONE);
        boot_err_d  = (state_d == S_ERR);
    end

    assign rom_we    = rom_we_q;
    assign rom_waddr = rom_waddr_q;
    assign rom_wdata = rom_wdata_q;
    assign core_rst  = core_rst_q;
    assign boot_done = boot_done_q;
    assign boot_err  = boot_err_q;

endmodule

// File: tb/tb_rom_boot_loader.sv
// Scoreboard bench for rom_boot_loader: a byte-stream reference model predicts ROM writes
// and final status; a monitor pops expected writes whenever rom_we is seen.
module tb_rom_boot_loader;

    localparam int ADDR_W = 12;
    localparam int CPB    = 16;
`ifdef BOOT_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              uart_rxd = 1'b1;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_waddr;
    logic [31:0]       rom_wdata;
    logic              core_rst, boot_done, boot_err;

    int   vectors = 0;
    int   miscompares = 0;
    wr_t  exp_q[$];
    logic [7:0] stim_b[$];
    bit         stim_ok[$];
    bit   exp_done, exp_err;
    int   gap_max = 0;

    rom_boot_loader #(.CLK_FREQ(50_000_000), .BAUD(50_000_000 / CPB), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .rom_we(rom_we), .rom_waddr(rom_waddr),
        .rom_wdata(rom_wdata), .core_rst(core_rst), .boot_done(boot_done), .boot_err(boot_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rom_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr %0h data %0h, none expected", rom_waddr, rom_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("rom_write", {20'd0, rom_waddr, rom_wdata}, {20'd0, e.addr, e.data});
            end
        end
    end

    // Reference: parse the byte stream positionally (length, words, optional sum).
    task automatic model_push();
        logic [31:0] n = 32'd0;
        logic [31:0] w = 32'd0;
        logic [7:0]  sum = 8'd0;
        bit ended = 1'b0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        for (int k = 0; k < stim_b.size(); k++) begin
            if (ended) break;
            if (!stim_ok[k]) begin
                exp_err = 1'b1;
                ended = 1'b1;
            end else if (k < 4) begin
                n = n | (32'(stim_b[k]) << (8 * k));
                if (k == 3) begin
                    if (n > 32'd4096) begin
                        exp_err = 1'b1; ended = 1'b1;
                    end else if (n == 32'd0 && !CK) begin
                        exp_done = 1'b1; ended = 1'b1;
                    end
                end
            end else if (k < 4 + 4 * int'(n)) begin
                w = w | (32'(stim_b[k]) << (8 * ((k - 4) % 4)));
                if ((k - 4) % 4 == 3) begin
                    exp_q.push_back('{addr: ADDR_W'((k - 4) / 4), data: w});
                    w = 32'd0;
                    if ((k - 4) / 4 == int'(n) - 1 && !CK) begin
                        exp_done = 1'b1; ended = 1'b1;
                    end
                end
            end else begin
                if (stim_b[k] == sum) exp_done = 1'b1;
                else exp_err = 1'b1;
                ended = 1'b1;
            end
            sum = sum + stim_b[k];
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        @(posedge clk); #1;
        uart_rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 uart_rxd = b[i];
            repeat (CPB) @(posedge clk);
        end
        #1 uart_rxd = stop_ok;
        repeat (CPB) @(posedge clk);
        #1 uart_rxd = 1'b1;
        repeat (1 + ((gap_max > 0) ? $urandom_range(0, gap_max) : 0)) @(posedge clk);
    endtask

    task automatic add(input logic [7:0] b);
        stim_b.push_back(b);
        stim_ok.push_back(1'b1);
    endtask

    task automatic add_case2();
        logic [7:0] img[12] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                                8'hef, 8'hbe, 8'had, 8'hde};
        foreach (img[i]) add(img[i]);
    endtask

    task automatic run_image(input string tag);
        model_push();
        for (int k = 0; k < stim_b.size(); k++) send_byte(stim_b[k], stim_ok[k]);
        stim_b.delete();
        stim_ok.delete();
        repeat (4 * CPB) @(posedge clk);
        @(negedge clk);
        check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_boot_done"}, 64'(boot_done), 64'(exp_done));
        check({tag, "_boot_err"}, 64'(boot_err), 64'(exp_err));
        check({tag, "_core_rst"}, 64'(core_rst), 64'(!exp_done));
        exp_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        check({tag, "_core_rst"}, 64'(core_rst), 64'd1);
        check({tag, "_rom_we"}, 64'(rom_we), 64'd0);
        check({tag, "_rom_waddr"}, 64'(rom_waddr), 64'd0);
        check({tag, "_rom_wdata"}, 64'(rom_wdata), 64'd0);
        check({tag, "_boot_done"}, 64'(boot_done), 64'd0);
        check({tag, "_boot_err"}, 64'(boot_err), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        check_reset_vals("in_reset");
        #1 rst = 1'b0;
        repeat (50) @(posedge clk);
        check_reset_vals("idle");

        add_case2();
        if (CK) add(8'h4d);
        add(8'haa); add(8'h55);
        run_image("two_words");

        do_reset();
        add(8'h00); add(8'h00); add(8'h00); add(8'h00);
        if (CK) add(8'h00);
        run_image("zero_len");

        do_reset();
        add(8'h01); add(8'h10); add(8'h00); add(8'h00);
        run_image("too_long");

        do_reset();
        add(8'h02); add(8'h00);
        stim_b.push_back(8'h00); stim_ok.push_back(1'b0);
        run_image("bad_stop");

        do_reset();
        @(posedge clk); #1 uart_rxd = 1'b0;
        repeat (CPB / 4) @(posedge clk);
        #1 uart_rxd = 1'b1;
        run_image("glitch");
        add_case2();
        if (CK) add(8'h4d);
        run_image("after_glitch");

        do_reset();
        add(8'h02); add(8'h00); add(8'h00); add(8'h00); add(8'h13); add(8'h00);
        run_image("partial");
        do_reset();
        check_reset_vals("mid_reset");
        add_case2();
        if (CK) add(8'h4d);
        run_image("resend");

        if (CK) begin
            do_reset();
            add_case2();
            add(8'h4c);
            run_image("bad_sum");
        end

        gap_max = 12;
        for (int it = 0; it < 5; it++) begin
            int n;
            logic [7:0] sum;
            do_reset();
            n = $urandom_range(1, 5);
            for (int i = 0; i < 4; i++) add(8'((n >> (8 * i)) & 255));
            for (int i = 0; i < 4 * n; i++) add(8'($urandom_range(0, 255)));
            sum = 8'd0;
            foreach (stim_b[i]) sum = sum + stim_b[i];
            if (CK) add(($urandom_range(0, 3) == 0) ? sum ^ 8'h01 : sum);
            if ($urandom_range(0, 2) == 0) stim_ok[$urandom_range(0, stim_ok.size() - 1)] = 1'b0;
            run_image("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
